// File: rtl/rhythm_recorder.sv
// Records button presses against the beat tick into a rhythm map laid out for the game datapath.
// Build option: define RHYTHM_RECORDER_DEBOUNCE_EN to insert the debounce filter after the synchronizers.
module rhythm_recorder #(
  parameter int unsigned MAP_LEN         = 191,
  parameter int unsigned OFFSET          = 1,
  parameter int unsigned DEBOUNCE_CYCLES = 250000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               tick,
  input  logic               arm,
  input  logic               button,
  output logic [MAP_LEN-1:0] map,
  output logic [7:0]         beat_count,
  output logic [7:0]         note_count,
  output logic               recording,
  output logic               done
);

  localparam int unsigned CH     = 2;
  localparam int unsigned IDX_W  = (MAP_LEN > 1) ? $clog2(MAP_LEN) : 1;
  localparam int unsigned SLOT_W = 9;

  if (MAP_LEN > 255 + OFFSET || OFFSET >= MAP_LEN || DEBOUNCE_CYCLES == 0) begin : g_bad_cfg
    $error("rhythm_recorder: illegal parameter combination");
  end

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RECORD = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Channel 0 is the arm key, channel 1 the play key; both idle high.
  logic [CH-1:0] w_pin;
  logic [CH-1:0] r_sync1;
  logic [CH-1:0] r_sync2;
  logic [CH-1:0] w_filt;
  logic [CH-1:0] r_filt_d;
  logic [CH-1:0] w_fall;
  logic          w_arm_edge;
  logic          w_press;

  assign w_pin = {button, arm};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= w_pin;
      r_sync2 <= r_sync1;
    end
  end

`ifdef RHYTHM_RECORDER_DEBOUNCE_EN
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic [DB_W-1:0] r_db_cnt [CH];
  logic [CH-1:0]   r_filt;

  // A level is accepted once it has differed from the filtered value for DEBOUNCE_CYCLES clocks.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt <= '1;
      for (int i = 0; i < int'(CH); i++) begin
        r_db_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(CH); i++) begin
        if (r_sync2[i] == r_filt[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
          r_filt[i]   <= r_sync2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
        end
      end
    end
  end

  assign w_filt = r_filt;
`else
  assign w_filt = r_sync2;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_filt_d <= '1;
    end else begin
      r_filt_d <= w_filt;
    end
  end

  assign w_fall     = r_filt_d & ~w_filt;
  assign w_arm_edge = w_fall[0];
  assign w_press    = w_fall[1];

  state_t             r_state;
  logic [MAP_LEN-1:0] r_map;
  logic [7:0]         r_beat_count;
  logic [7:0]         r_note_count;
  logic               r_pending;
  logic               r_recording;
  logic               r_done;

  logic [SLOT_W-1:0]  w_slot;
  logic [IDX_W-1:0]   w_idx;
  logic               w_last;
  logic               w_note;

  assign w_slot = {1'b0, r_beat_count} + SLOT_W'(OFFSET);
  assign w_idx  = w_slot[IDX_W-1:0];
  assign w_last = (w_slot == SLOT_W'(MAP_LEN - 1));
  // A press arriving with the tick still belongs to the beat that tick closes.
  assign w_note = r_pending | w_press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_map        <= '0;
      r_beat_count <= '0;
      r_note_count <= '0;
      r_pending    <= 1'b0;
      r_recording  <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_arm_edge) begin
            r_state      <= S_RECORD;
            r_map        <= '0;
            r_beat_count <= '0;
            r_note_count <= '0;
            r_pending    <= 1'b0;
            r_recording  <= 1'b1;
            r_done       <= 1'b0;
          end
        end
        S_RECORD: begin
          if (w_arm_edge) begin
            r_state     <= S_DONE;
            r_pending   <= 1'b0;
            r_recording <= 1'b0;
            r_done      <= 1'b1;
          end else if (tick) begin
            r_map[w_idx] <= w_note;
            if (w_note && (r_note_count != 8'hFF)) begin
              r_note_count <= r_note_count + 8'd1;
            end
            r_beat_count <= r_beat_count + 8'd1;
            r_pending    <= 1'b0;
            if (w_last) begin
              r_state     <= S_DONE;
              r_recording <= 1'b0;
              r_done      <= 1'b1;
            end
          end else if (w_press) begin
            r_pending <= 1'b1;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_recording <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign map        = r_map;
  assign beat_count = r_beat_count;
  assign note_count = r_note_count;
  assign recording  = r_recording;
  assign done       = r_done;

endmodule

// File: tb/tb_rhythm_recorder.sv
// Scoreboard bench for rhythm_recorder: a beat-level model pushes the expected state at each tick.
module tb_rhythm_recorder;

  localparam int unsigned MAP_LEN   = 16;
  localparam int unsigned OFFSET    = 1;
  localparam int unsigned DB        = 4;
  localparam int          BEAT_CLKS = 50;
`ifdef RHYTHM_RECORDER_DEBOUNCE_EN
  localparam int PLAT        = 3 + int'(DB);
  localparam bit GLITCH_NOTE = 1'b0;
`else
  localparam int PLAT        = 3;
  localparam bit GLITCH_NOTE = 1'b1;
`endif

  logic               clk    = 1'b0;
  logic               rst    = 1'b0;
  logic               tick   = 1'b0;
  logic               arm    = 1'b1;
  logic               button = 1'b1;
  logic [MAP_LEN-1:0] map;
  logic [7:0]         beat_count;
  logic [7:0]         note_count;
  logic               recording;
  logic               done;

  rhythm_recorder #(
    .MAP_LEN         (MAP_LEN),
    .OFFSET          (OFFSET),
    .DEBOUNCE_CYCLES (DB)
  ) u_dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .arm        (arm),
    .button     (button),
    .map        (map),
    .beat_count (beat_count),
    .note_count (note_count),
    .recording  (recording),
    .done       (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] map;
    logic [7:0]  beats;
    logic [7:0]  notes;
    logic        rec;
    logic        done;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          beat_cyc = 0;
  logic [15:0] m_map  = '0;
  int          m_beat = 0;
  int          m_note = 0;
  bit          m_rec  = 1'b0;
  bit          m_done = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model_now();
    exp_t e;
    e.map   = m_map;
    e.beats = 8'(m_beat);
    e.notes = 8'(m_note);
    e.rec   = m_rec;
    e.done  = m_done;
    return e;
  endfunction

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".map"},  32'(map),        32'(e.map));
    check({tag, ".beat"}, 32'(beat_count), 32'(e.beats));
    check({tag, ".note"}, 32'(note_count), 32'(e.notes));
    check({tag, ".rec"},  32'(recording),  32'(e.rec));
    check({tag, ".done"}, 32'(done),       32'(e.done));
  endtask

  task automatic clks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      beat_cyc++;
    end
  endtask

  task automatic press_btn(input int low);
    button = 1'b0;
    clks(low);
    button = 1'b1;
    clks(PLAT + 1);
  endtask

  // Arm key press; the model toggles between recording and done.
  task automatic arm_key(input string tag);
    arm = 1'b0;
    clks(PLAT + 3);
    arm = 1'b1;
    clks(PLAT + 3);
    if (m_rec) begin
      m_rec  = 1'b0;
      m_done = 1'b1;
    end else begin
      m_map  = '0;
      m_beat = 0;
      m_note = 0;
      m_rec  = 1'b1;
      m_done = 1'b0;
    end
    check_outputs(tag, model_now());
  endtask

  task automatic do_tick(input bit noted);
    exp_t got_e;
    if (m_rec) begin
      if (noted) begin
        m_map[m_beat + int'(OFFSET)] = 1'b1;
        if (m_note < 255) m_note++;
      end
      if (m_beat + int'(OFFSET) == int'(MAP_LEN) - 1) begin
        m_rec  = 1'b0;
        m_done = 1'b1;
      end
      m_beat++;
    end
    sb.push_back(model_now());
    tick = 1'b1;
    clks(1);
    tick = 1'b0;
    got_e = sb.pop_front();
    check_outputs($sformatf("tick%0d", m_beat), got_e);
  endtask

  // mode: 0 silent, 1 one press, 2 three presses, 3 press lands on the tick, 4 short glitch
  task automatic run_beat(input int mode);
    bit noted;
    beat_cyc = 0;
    noted    = 1'b0;
    case (mode)
      1: begin press_btn(8); noted = 1'b1; end
      2: begin repeat (3) press_btn(7); noted = 1'b1; end
      3: begin
        noted = 1'b1;
        clks(BEAT_CLKS - PLAT);
        button = 1'b0;
        clks(PLAT - 1);
      end
      4: begin
        button = 1'b0;
        clks(3);
        button = 1'b1;
        noted = GLITCH_NOTE;
      end
      default: ;
    endcase
    if (mode != 3 && beat_cyc < BEAT_CLKS - 1) clks(BEAT_CLKS - 1 - beat_cyc);
    do_tick(noted);
    if (mode == 3) begin
      clks(3);
      button = 1'b1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rec2 [15] = '{0, 0, 2, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0, 0, 0};

    clks(3);
    check_outputs("reset", model_now());
    rst = 1'b1;
    clks(2);

    // Presses in beats 0, 3 and 14 of a full recording.
    arm_key("arm1");
    for (int b = 0; b < 15; b++) run_beat((b == 0 || b == 3 || b == 14) ? 1 : 0);
    check({"rec1.final_map"}, 32'(map), 32'h0000_8012);

    // Triple press, press on the tick, glitch.
    arm_key("arm2");
    for (int b = 0; b < 15; b++) run_beat(rec2[b]);

    // Abort with a pending note, then restart.
    arm_key("arm3");
    for (int b = 0; b < 4; b++) run_beat(0);
    press_btn(8);
    arm_key("abort");
    run_beat(1);
    arm_key("rearm");

    // Asynchronous reset in the middle of a recording.
    run_beat(1);
    press_btn(8);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    m_map  = '0;
    m_beat = 0;
    m_note = 0;
    m_rec  = 1'b0;
    m_done = 1'b0;
    check_outputs("async_rst", model_now());
    @(negedge clk);
    rst = 1'b1;
    run_beat(1);
    run_beat(1);
    arm_key("post_rst_arm");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
